mux_pipe: RTL and testbench
===========================

MUX_PIPE -- requirements
Module: mux_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32: data width per input channel, in bits.
REQ-002 SHALL have parameter N_IN, default 4: number of input channels, minimum 2.
REQ-003 SHALL have derived localparam SEL_W = max(1, clog2(N_IN)): select width.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port in_data  input  N_IN*WIDTH  packed channels; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-007 SHALL have port sel  input  SEL_W  channel select, qualified by in_valid.
REQ-008 SHALL have port in_valid  input  1  producer offers in_data/sel this cycle.
REQ-009 SHALL have port in_ready  output  1  block accepts this cycle.
REQ-010 SHALL have port flush  input  1  discard all buffered words.
REQ-011 SHALL have port out_data  output  WIDTH  selected, registered word.
REQ-012 SHALL have port out_sel_err  output  1  select was >= N_IN for the word on out_data.
REQ-013 SHALL have port out_valid  output  1  out_data holds a valid word.
REQ-014 SHALL have port out_ready  input  1  consumer accepts this cycle.

Function
REQ-015 SHALL accept a word only on a cycle with in_valid=1 and in_ready=1.
REQ-016 SHALL register the selected channel with 1-cycle latency: a word accepted in cycle t SHALL be presentable on out_data in cycle t+1.
REQ-017 SHALL, for sel >= N_IN, store data 0 with out_sel_err=1; otherwise out_sel_err=0.
REQ-018 SHALL transfer an output word only on a cycle with out_valid=1 and out_ready=1.
REQ-019 SHALL hold out_data, out_sel_err and out_valid stable while out_valid=1 and out_ready=0.
REQ-020 SHALL deliver words in acceptance order, with no loss and no duplication.
REQ-021 SHALL, on flush=1, clear every valid flag at the next edge; an accept in the same cycle is dropped; out_valid=0 and in_ready=1 the following cycle.
REQ-022 SHALL have flush take priority over simultaneous accept and transfer events.
REQ-023 SHALL treat in_data and sel as don't-care when in_valid=0, and capture nothing in that case.

Reset
REQ-024 SHALL, while rst=1, force out_valid=0, out_data=0 and out_sel_err=0 at each edge, and clear the skid entry.
REQ-025 SHALL hold in_ready=0 during reset cycles and drive in_ready=1 on the first cycle after rst deasserts.
REQ-026 SHALL have a reset asserted mid-transfer discard all buffered words; the discarded words are not delivered.
REQ-027 SHALL give rst priority over flush.

Configuration
REQ-028 SHALL support macro MUX_PIPE_SKID_EN.
REQ-029 SHALL, with MUX_PIPE_SKID_EN defined, implement a 2-entry skid buffer with states EMPTY, ONE and TWO.
REQ-030 SHALL, with MUX_PIPE_SKID_EN defined, drive in_ready directly from a register: in_ready=0 only in state TWO.
REQ-031 SHALL, with MUX_PIPE_SKID_EN defined, use these transitions:
- EMPTY to ONE on accept;
- ONE to TWO on accept without transfer;
- ONE to EMPTY on transfer without accept;
- TWO to ONE on transfer; the skid word moves to the output register.
REQ-032 SHALL, with MUX_PIPE_SKID_EN defined, sustain 1 word per cycle with out_ready=1.
REQ-033 SHALL, without MUX_PIPE_SKID_EN, use a single output register with combinational in_ready = !out_valid || out_ready.
REQ-034 SHALL, without MUX_PIPE_SKID_EN, still sustain 1 word per cycle with out_ready=1.
REQ-035 SHALL behave identically at the port level in both builds except for the in_ready timing.

Verification
REQ-036 SHALL cover: N_IN=4, in_data={D,C,B,A}, sel=2, single accept -> next cycle out_valid=1, out_data=C, out_sel_err=0.
REQ-037 SHALL cover: N_IN=3, sel=3 -> out_data=0x00000000, out_sel_err=1.
REQ-038 SHALL cover: SKID_EN build, out_ready=0, 3 offers of 0x11, 0x22, 0x33 -> first two accepted, in_ready=0 on the 3rd; release -> 0x11 then 0x22 delivered, then 0x33 accepted.
REQ-039 SHALL cover: continuous in_valid=1 and out_ready=1 for 16 cycles, incrementing data -> 16 words delivered in order, 1 per cycle, in both builds.
REQ-040 SHALL cover: TWO state plus flush=1 and in_valid=1 in the same cycle -> next cycle out_valid=0 and in_ready=1; no stale word ever appears.
REQ-041 SHALL cover: rst pulsed while out_valid=1 and out_ready=0 -> out_valid=0 and out_data=0; in_ready=1 on the first cycle after release.

Source files
------------

// File: rtl/mux_pipe.sv
// mux_pipe: N_IN-to-1 word selector feeding a registered, back-pressured output.
// An out-of-range select stores a zero word and raises out_sel_err.
// Build option MUX_PIPE_SKID_EN: adds a 2-entry skid buffer so that in_ready comes from a register.
// Without the option, a single output register is used and in_ready is combinational.
//
// state | meaning (MUX_PIPE_SKID_EN build)
// EMPTY | no word held; out_valid=0
// ONE   | output register holds a word; skid entry free
// TWO   | output register and skid entry both hold a word; in_ready=0
module mux_pipe #(
    parameter  int WIDTH = 32,
    parameter  int N_IN  = 4,
    localparam int SEL_W = (N_IN > 2) ? $clog2(N_IN) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]      sel,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  flush,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_sel_err,
    output logic                  out_valid,
    input  logic                  out_ready
);

    logic [WIDTH-1:0] mux_data;
    logic             mux_err;
    logic             acc;
    logic             xfer;

    // Pick the selected channel; a select with no matching channel yields zero plus the error flag.
    always_comb begin
        mux_data = '0;
        mux_err  = 1'b1;
        for (int k = 0; k < N_IN; k++) begin
            if (int'(sel) == k) begin
                mux_data = in_data[k*WIDTH +: WIDTH];
                mux_err  = 1'b0;
            end
        end
    end

    assign acc  = in_valid && in_ready;
    assign xfer = out_valid && out_ready;

`ifdef MUX_PIPE_SKID_EN

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_err_q, out_err_d;
    logic [WIDTH-1:0] skid_data_q, skid_data_d;
    logic             skid_err_q, skid_err_d;
    logic             rdy_q;

    // rdy_q already reflects the next state; gating with rst keeps in_ready low during reset
    // and lets it rise on the first cycle after release.
    assign in_ready    = rdy_q && !rst;
    assign out_valid   = (state_q != EMPTY);
    assign out_data    = out_data_q;
    assign out_sel_err = out_err_q;

    // Next-state and data movement between input, skid entry and output register.
    always_comb begin
        state_d     = state_q;
        out_data_d  = out_data_q;
        out_err_d   = out_err_q;
        skid_data_d = skid_data_q;
        skid_err_d  = skid_err_q;
        case (state_q)
            EMPTY: begin
                if (acc) begin
                    out_data_d = mux_data;
                    out_err_d  = mux_err;
                    state_d    = ONE;
                end
            end
            ONE: begin
                if (acc && xfer) begin
                    out_data_d = mux_data;
                    out_err_d  = mux_err;
                end else if (acc) begin
                    skid_data_d = mux_data;
                    skid_err_d  = mux_err;
                    state_d     = TWO;
                end else if (xfer) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                if (xfer) begin
                    out_data_d = skid_data_q;
                    out_err_d  = skid_err_q;
                    state_d    = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
        if (flush) begin
            state_d = EMPTY;
        end
    end

    // State and data registers; reset wins over flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= EMPTY;
            out_data_q  <= '0;
            out_err_q   <= 1'b0;
            skid_data_q <= '0;
            skid_err_q  <= 1'b0;
            rdy_q       <= 1'b1;
        end else begin
            state_q     <= state_d;
            out_data_q  <= out_data_d;
            out_err_q   <= out_err_d;
            skid_data_q <= skid_data_d;
            skid_err_q  <= skid_err_d;
            rdy_q       <= (state_d != TWO);
        end
    end

`else

    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_err_q, out_err_d;
    logic             out_valid_q, out_valid_d;

    assign in_ready    = !rst && (!out_valid_q || out_ready);
    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign out_sel_err = out_err_q;

    // Load on accept, drop the valid flag on a transfer with no replacement; flush clears it.
    always_comb begin
        out_data_d  = out_data_q;
        out_err_d   = out_err_q;
        out_valid_d = out_valid_q;
        if (acc) begin
            out_data_d  = mux_data;
            out_err_d   = mux_err;
            out_valid_d = 1'b1;
        end else if (xfer) begin
            out_valid_d = 1'b0;
        end
        if (flush) begin
            out_valid_d = 1'b0;
        end
    end

    // Output register; reset wins over flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data_q  <= '0;
            out_err_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            out_data_q  <= out_data_d;
            out_err_q   <= out_err_d;
            out_valid_q <= out_valid_d;
        end
    end

`endif

endmodule

// File: tb/tb_mux_pipe.sv
// Directed testbench for mux_pipe; works for both builds (MUX_PIPE_SKID_EN defined or not).
module tb_mux_pipe;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] in_data;
    logic [1:0]   sel;
    logic         in_valid;
    logic         in_ready;
    logic         flush;
    logic [31:0]  out_data;
    logic         out_sel_err;
    logic         out_valid;
    logic         out_ready;

    logic [95:0]  in_data3;
    logic [1:0]   sel3;
    logic         in_valid3;
    logic         in_ready3;
    logic         flush3;
    logic [31:0]  out_data3;
    logic         out_sel_err3;
    logic         out_valid3;
    logic         out_ready3;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mux_pipe #(.WIDTH(32), .N_IN(4)) u_dut (
        .clk(clk), .rst(rst), .in_data(in_data), .sel(sel), .in_valid(in_valid),
        .in_ready(in_ready), .flush(flush), .out_data(out_data), .out_sel_err(out_sel_err),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    mux_pipe #(.WIDTH(32), .N_IN(3)) u_dut3 (
        .clk(clk), .rst(rst), .in_data(in_data3), .sel(sel3), .in_valid(in_valid3),
        .in_ready(in_ready3), .flush(flush3), .out_data(out_data3), .out_sel_err(out_sel_err3),
        .out_valid(out_valid3), .out_ready(out_ready3)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] w);
        in_valid = 1'b1;
        sel      = 2'd0;
        in_data  = {96'b0, w};
    endtask

    initial begin
        rst = 1'b1; in_data = '0; sel = '0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        in_data3 = '0; sel3 = '0; in_valid3 = 1'b0; flush3 = 1'b0; out_ready3 = 1'b1;

        // reset state
        tick(); tick();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_err", out_sel_err, 0);
        chk("rst_in_ready", in_ready, 0);
        rst = 1'b0;
        #1;
        chk("rel_in_ready", in_ready, 1);

        // single accept, sel=2 picks channel C
        in_data  = {32'hDDDD_DDDD, 32'hCCCC_CCCC, 32'hBBBB_BBBB, 32'hAAAA_AAAA};
        sel      = 2'd2;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("sel2_valid", out_valid, 1);
        chk("sel2_data", out_data, 64'hCCCC_CCCC);
        chk("sel2_err", out_sel_err, 0);
        out_ready = 1'b1;
        tick();
        chk("sel2_drained", out_valid, 0);

        // every channel once
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            sel      = 2'(k);
            tick();
            chk("chan_data", out_data, {32'b0, in_data[k*32 +: 32]});
        end
        in_valid = 1'b0;
        tick();

        // N_IN=3: out-of-range select gives zero and the error flag
        in_data3  = {32'h0000_0333, 32'h0000_0222, 32'h0000_0111};
        sel3      = 2'd3;
        in_valid3 = 1'b1;
        tick();
        chk("oor_valid", out_valid3, 1);
        chk("oor_data", out_data3, 0);
        chk("oor_err", out_sel_err3, 1);
        sel3 = 2'd1;
        tick();
        in_valid3 = 1'b0;
        chk("n3_data", out_data3, 64'h222);
        chk("n3_err", out_sel_err3, 0);
        tick();
        chk("n3_drained", out_valid3, 0);

        // back-pressure: 0x11, 0x22, 0x33 offered with out_ready=0
        out_ready = 1'b0;
        offer(32'h11);
        #1;
        chk("bp_rdy1", in_ready, 1);
        tick();
`ifdef MUX_PIPE_SKID_EN
        offer(32'h22);
        #1;
        chk("bp_rdy2", in_ready, 1);
        tick();
        offer(32'h33);
        #1;
        chk("bp_rdy3", in_ready, 0);
        tick();
        chk("bp_hold", out_data, 64'h11);
        out_ready = 1'b1;
        #1;
        chk("bp_rel_rdy", in_ready, 0);
        tick();
        chk("bp_w2", out_data, 64'h22);
        chk("bp_rdy_after", in_ready, 1);
        tick();
        in_valid = 1'b0;
        chk("bp_w3", out_data, 64'h33);
`else
        offer(32'h22);
        #1;
        chk("bp_rdy2", in_ready, 0);
        tick();
        chk("bp_hold", out_data, 64'h11);
        out_ready = 1'b1;
        #1;
        chk("bp_rel_rdy", in_ready, 1);
        tick();
        chk("bp_w2", out_data, 64'h22);
        offer(32'h33);
        tick();
        in_valid = 1'b0;
        chk("bp_w3", out_data, 64'h33);
`endif
        chk("bp_w3_valid", out_valid, 1);
        tick();
        chk("bp_drained", out_valid, 0);

        // streaming: 16 words, one per cycle
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            offer(32'h100 + 32'(i));
            #1;
            chk("str_rdy", in_ready, 1);
            tick();
            chk("str_valid", out_valid, 1);
            chk("str_data", out_data, 64'h100 + 64'(i));
        end
        in_valid = 1'b0;
        tick();
        chk("str_drained", out_valid, 0);

        // flush with buffered words and a simultaneous offer
        out_ready = 1'b0;
        offer(32'hA1);
        tick();
        offer(32'hA2);
        tick();
        offer(32'hA3);
        flush = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("fl_valid", out_valid, 0);
        chk("fl_rdy", in_ready, 1);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("fl_no_stale", out_valid, 0);
        end
        offer(32'hB1);
        tick();
        in_valid = 1'b0;
        chk("fl_next_data", out_data, 64'hB1);
        tick();
        chk("fl_next_drained", out_valid, 0);

        // reset (with flush) asserted while stalled
        out_ready = 1'b0;
        offer(32'h5A);
        tick();
        offer(32'h5B);
        tick();
        in_valid = 1'b0;
        chk("mr_pre_valid", out_valid, 1);
        rst   = 1'b1;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("mr_valid", out_valid, 0);
        chk("mr_data", out_data, 0);
        chk("mr_err", out_sel_err, 0);
        chk("mr_rdy", in_ready, 0);
        rst = 1'b0;
        #1;
        chk("mr_rel_rdy", in_ready, 1);
        out_ready = 1'b1;
        tick();
        chk("mr_discard", out_valid, 0);
        tick();
        chk("mr_discard2", out_valid, 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
